branch_hazard_ctrl: RTL
=======================

// Module: branch_hazard_ctrl
// PURPOSE
//  Control unit for the 5-stage pipelined processor (IF/ID/EX/MEM/WB).
//  Predicts branch direction in IF from a 2-bit-counter branch history table (BHT).
//  Resolves each prediction in EX and issues PC redirect and flush on a mispredict.
//  Detects load-use hazards and issues stall/bubble. Keeps saturating perf counters.
// PARAMETERS
//  IDX_BITS   6       BHT index width; table holds 2**IDX_BITS 2-bit counters
//  CNT_W      16      width of perf counters
// PORTS
//  clock           in   1        system clock, rising edge
//  reset_n         in   1        asynchronous, active-low reset
//  if_pc           in   32       PC of instruction in IF
//  pred_taken      out  1        BHT prediction for if_pc (MSB of counter)
//  ex_br_valid     in   1        conditional branch is resolving in EX this cycle
//  ex_pc           in   32       PC of branch in EX
//  ex_taken        in   1        actual branch outcome
//  ex_pred_taken   in   1        prediction made for this branch in IF (piped down)
//  ex_target       in   32       computed branch target
//  id_rs1, id_rs2  in   5 each   source registers of instruction in ID
//  ex_mem_read     in   1        instruction in EX is a load
//  ex_rd           in   5        destination register of instruction in EX
//  redirect_valid  out  1        IF must load redirect_pc next edge
//  redirect_pc     out  32       corrected PC
//  stall_pc        out  1        hold PC register
//  stall_if_id     out  1        hold IF/ID register
//  flush_if_id     out  1        zero IF/ID (insert NOP)
//  flush_id_ex     out  1        zero ID/EX (insert bubble)
//  br_count        out  CNT_W    branches resolved
//  mispred_count   out  CNT_W    mispredicts
// BEHAVIOUR
//  BHT index = pc[IDX_BITS+1:2]. Counter states: 00 SNT, 01 WNT, 10 WT, 11 ST.
//  - Reset: all entries 01. Both counters 0.
//  - All outputs are 0 while reset_n is low.
//  - Reset asserted mid-operation clears immediately (async). No stale redirect after release.
//  Prediction:
//  - pred_taken is a combinational read of bht[idx(if_pc)]. Latency 0.
//  - No bypass: if the same index is updated in the same cycle, the pre-update value is used.
//  Update:
//  - On posedge clock with ex_br_valid=1, bht[idx(ex_pc)] increments on ex_taken, else decrements.
//  - The counter saturates at 11 and at 00.
//  - br_count += 1 on each update, saturating at all-ones.
//  Mispredict:
//  - Condition: mispredict = ex_br_valid & (ex_taken != ex_pred_taken). Combinational.
//  - redirect_valid=1.
//  - redirect_pc = ex_taken ? ex_target : ex_pc+4 (32-bit wrap, no carry-out).
//  - flush_if_id=1 and flush_id_ex=1 in the same cycle.
//  - mispred_count += 1 at the edge, saturating.
//  - When redirect_valid=0, redirect_pc is 0.
//  Load-use:
//  - Condition: luse = ex_mem_read & (ex_rd!=0) & (ex_rd==id_rs1 | ex_rd==id_rs2).
//  - Response: stall_pc=1, stall_if_id=1, flush_id_ex=1 for exactly the cycles luse holds.
//  - The stall is one cycle per hazard because the bubble clears ex_mem_read.
//  Priority:
//  - Mispredict beats load-use.
//  - If both are true, stall_pc=stall_if_id=0. The flushed ID instruction is dead.
//  - Output is mispredict response only.
//  Other:
//  - ex_br_valid=0 means no update and no redirect, regardless of the other EX inputs.
//  - Back-to-back branches each update in their own cycle; no hazard on the same index.
// TESTING
//  1 Reset then read if_pc=0x00 -> pred_taken=0; BHT[0]=01; counters 0; all ctl outputs 0.
//  2 Branch pc=0x40, taken, pred=0, target 0x80 -> redirect_valid=1, redirect_pc=0x80,
//    both flushes=1, mispred_count=1.
//    Next cycle, if_pc=0x40 -> pred_taken=1 (10).
//  3 Four more taken updates at 0x40 -> saturates 11; then one not-taken -> 10,
//    pred_taken stays 1; mispred on not-taken -> redirect_pc=0x44.
//  4 ex_mem_read=1, ex_rd=5, id_rs2=5 -> stall_pc=stall_if_id=flush_id_ex=1 one cycle;
//    ex_rd=0 with id_rs1=0 -> no stall.
//  5 Load-use and mispredict in the same cycle -> stall_pc=0, redirect_valid=1,
//    flush_if_id=flush_id_ex=1.
//  6 Assert reset_n=0 mid-redirect -> outputs 0 immediately; BHT back to 01;
//    with CNT_W=2, four mispredicts -> mispred_count holds 3.

Source files
------------

// File: rtl/branch_hazard_ctrl.sv
// branch_hazard_ctrl
//   Branch prediction and hazard control for a 5-stage pipeline.
//   IF  : 2-bit saturating-counter BHT lookup -> pred_taken (combinational).
//   EX  : branch resolution, BHT update, PC redirect + IF/ID and ID/EX flush
//         on mispredict.
//   ID  : load-use detection -> stall PC and IF/ID, bubble into ID/EX.
//   Saturating counters of resolved branches and mispredicts.
// Ports
//   clock, reset_n                   clock (rising edge), async active-low reset
//   if_pc / pred_taken               IF lookup and its prediction
//   ex_br_valid, ex_pc, ex_taken,
//   ex_pred_taken, ex_target         resolving branch in EX
//   id_rs1, id_rs2                   sources of the instruction in ID
//   ex_mem_read, ex_rd               load in EX and its destination
//   redirect_valid, redirect_pc      PC correction for IF
//   stall_pc, stall_if_id            hold PC and IF/ID
//   flush_if_id, flush_id_ex         squash IF/ID and ID/EX
//   br_count, mispred_count          perf counters
module branch_hazard_ctrl #(
    parameter int IDX_BITS = 6,
    parameter int CNT_W    = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [31:0]      if_pc,
    output logic             pred_taken,
    input  logic             ex_br_valid,
    input  logic [31:0]      ex_pc,
    input  logic             ex_taken,
    input  logic             ex_pred_taken,
    input  logic [31:0]      ex_target,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rd,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic             stall_pc,
    output logic             stall_if_id,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] mispred_count
);

    localparam int ENTRIES = 1 << IDX_BITS;

    logic [1:0]          bht [ENTRIES];
    logic [IDX_BITS-1:0] if_idx;
    logic [IDX_BITS-1:0] ex_idx;
    logic                mispredict;
    logic                luse;

    assign if_idx = if_pc[IDX_BITS+1:2];
    assign ex_idx = ex_pc[IDX_BITS+1:2];

    assign mispredict = ex_br_valid & (ex_taken != ex_pred_taken);
    assign luse       = ex_mem_read & (ex_rd != 5'd0) &
                        ((ex_rd == id_rs1) | (ex_rd == id_rs2));

    // Read is taken from the registered table, so a same-index update in
    // this cycle is not visible until the next one.
    assign pred_taken = reset_n & bht[if_idx][1];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                bht[i] <= 2'b01;
            end
        end else if (ex_br_valid) begin
            if (ex_taken) begin
                if (bht[ex_idx] != 2'b11) bht[ex_idx] <= bht[ex_idx] + 2'b01;
            end else begin
                if (bht[ex_idx] != 2'b00) bht[ex_idx] <= bht[ex_idx] - 2'b01;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            br_count      <= '0;
            mispred_count <= '0;
        end else begin
            if (ex_br_valid && (br_count != '1)) begin
                br_count <= br_count + CNT_W'(1);
            end
            if (mispredict && (mispred_count != '1)) begin
                mispred_count <= mispred_count + CNT_W'(1);
            end
        end
    end

    // Mispredict wins over load-use: the instruction in ID is flushed anyway,
    // so stalling it would only cost a cycle.
    always_comb begin
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        stall_pc       = 1'b0;
        stall_if_id    = 1'b0;
        flush_if_id    = 1'b0;
        flush_id_ex    = 1'b0;
        if (reset_n) begin
            if (mispredict) begin
                redirect_valid = 1'b1;
                redirect_pc    = ex_taken ? ex_target : (ex_pc + 32'd4);
                flush_if_id    = 1'b1;
                flush_id_ex    = 1'b1;
            end else if (luse) begin
                stall_pc    = 1'b1;
                stall_if_id = 1'b1;
                flush_id_ex = 1'b1;
            end
        end
    end

endmodule
